// File: rtl/memwr_seq.sv
// Memory write sequencer: latches a store request, steers byte data onto the proper lane,
// runs the MWE/ACK handshake and reports completion, odd-word rejection or timeout.
module memwr_seq #(
    parameter int unsigned TMO_CYCLES = 15,
    parameter int unsigned TMO_W      = 8
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        START,
    input  logic        WORD,
    input  logic [15:0] ADDR,
    input  logic [15:0] B,
    input  logic        ACK,
    output logic [15:0] MA,
    output logic [15:0] MD,
    output logic [1:0]  MBE,
    output logic        MWE,
    output logic        BUSY,
    output logic        DONE,
    output logic        ODDERR,
    output logic        NXM
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    // Counter value seen on the edge that closes the last permitted WRITE cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [15:0]      ma_q, ma_d;
    logic [15:0]      md_q, md_d;
    logic [1:0]       mbe_q, mbe_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             odderr_q, odderr_d;
    logic             nxm_q, nxm_d;

    always_comb begin
        state_d  = state_q;
        ma_d     = ma_q;
        md_d     = md_q;
        mbe_d    = mbe_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        odderr_d = 1'b0;
        nxm_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    if (WORD && ADDR[0]) begin
                        odderr_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                        ma_d    = ADDR;
                        cnt_d   = '0;
                        if (WORD) begin
                            md_d  = B;
                            mbe_d = 2'b11;
                        end else begin
                            // Byte data goes out on both lanes; MBE picks the one memory takes.
                            md_d  = {B[7:0], B[7:0]};
                            mbe_d = ADDR[0] ? 2'b10 : 2'b01;
                        end
                    end
                end
            end
            WRITE: begin
                if (ACK) begin
                    // ACK takes priority over a timeout landing on the same edge.
                    state_d = IDLE;
                    mbe_d   = 2'b00;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == TMO_LAST) begin
                        state_d = IDLE;
                        mbe_d   = 2'b00;
                        nxm_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mbe_d   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= IDLE;
            ma_q     <= '0;
            md_q     <= '0;
            mbe_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            odderr_q <= 1'b0;
            nxm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ma_q     <= ma_d;
            md_q     <= md_d;
            mbe_q    <= mbe_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            odderr_q <= odderr_d;
            nxm_q    <= nxm_d;
        end
    end

    assign MA     = ma_q;
    assign MD     = md_q;
    assign MBE    = mbe_q;
    assign MWE    = (state_q == WRITE);
    assign BUSY   = (state_q == WRITE);
    assign DONE   = done_q;
    assign ODDERR = odderr_q;
    assign NXM    = nxm_q;

`ifndef SYNTHESIS
    a_pulses_exclusive: assert property (@(posedge CLK) disable iff (!RSTN)
        $onehot0({DONE, ODDERR, NXM}));

    a_write_stable: assert property (@(posedge CLK) disable iff (!RSTN)
        (MWE && $past(MWE) && $past(RSTN)) |-> ($stable(MA) && $stable(MD) && $stable(MBE)));

    a_idle_no_enables: assert property (@(posedge CLK) disable iff (!RSTN)
        !MWE |-> (MBE == 2'b00));
`endif

endmodule

// File: tb/tb_memwr_seq.sv
// Self-checking bench for memwr_seq: directed scenarios plus randomized writes checked
// against a transaction-level model of the expected memory cycle.
module tb_memwr_seq;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic        START = 1'b0;
    logic        WORD = 1'b0;
    logic [15:0] ADDR = '0;
    logic [15:0] B = '0;
    logic        ACK = 1'b0;
    logic [15:0] MA;
    logic [15:0] MD;
    logic [1:0]  MBE;
    logic        MWE;
    logic        BUSY;
    logic        DONE;
    logic        ODDERR;
    logic        NXM;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_ma = '0;
    logic [15:0] last_md = '0;

    memwr_seq #(
        .TMO_CYCLES(TMO),
        .TMO_W     (8)
    ) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .START (START),
        .WORD  (WORD),
        .ADDR  (ADDR),
        .B     (B),
        .ACK   (ACK),
        .MA    (MA),
        .MD    (MD),
        .MBE   (MBE),
        .MWE   (MWE),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ODDERR(ODDERR),
        .NXM   (NXM)
    );

    always #5 CLK = ~CLK;

    // One store transaction; ack_cycle = WRITE cycle whose closing edge sees ACK (0 = never).
    task automatic do_write(input logic word, input logic [15:0] addr, input logic [15:0] b,
                            input int ack_cycle, input bit poke, input bit tail);
        logic [15:0] emd;
        logic [1:0]  embe;
        bit          exp_done;
        int          ecyc;
        int          cyc;
        emd      = word ? b : {b[7:0], b[7:0]};
        embe     = word ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
        exp_done = (ack_cycle >= 1 && ack_cycle <= TMO);
        ecyc     = exp_done ? ack_cycle : TMO;

        START = 1'b1; WORD = word; ADDR = addr; B = b; ACK = 1'b0;
        @(posedge CLK); #1;
        START = 1'b0;
        cyc = 0;
        while (MWE === 1'b1 && cyc < TMO + 4) begin
            checks++;
            if ({BUSY, DONE, ODDERR, NXM} !== 4'b1000) begin
                errors++;
                $display("FAIL write_flags cyc%0d: got %b expected 1000", cyc + 1,
                         {BUSY, DONE, ODDERR, NXM});
            end
            checks++;
            if ({MA, MD, MBE} !== {addr, emd, embe}) begin
                errors++;
                $display("FAIL write_bus cyc%0d: got MA=%h MD=%h MBE=%b expected %h %h %b",
                         cyc + 1, MA, MD, MBE, addr, emd, embe);
            end
            if (poke) begin
                START = 1'b1; WORD = ~word; ADDR = addr ^ 16'h0F0E; B = ~b;
            end
            ACK = (cyc + 1 == ack_cycle);
            @(posedge CLK); #1;
            ACK = 1'b0;
            START = 1'b0;
            cyc++;
        end
        checks++;
        if (cyc != ecyc) begin
            errors++;
            $display("FAIL mwe_cycles: got %0d expected %0d", cyc, ecyc);
        end
        checks++;
        if ({MWE, BUSY, MBE} !== 4'b0000) begin
            errors++;
            $display("FAIL end_idle: got MWE/BUSY/MBE=%b expected 0000", {MWE, BUSY, MBE});
        end
        checks++;
        if ({DONE, NXM, ODDERR} !== {exp_done, !exp_done, 1'b0}) begin
            errors++;
            $display("FAIL end_pulse: got DONE/NXM/ODDERR=%b expected %b",
                     {DONE, NXM, ODDERR}, {exp_done, !exp_done, 1'b0});
        end
        checks++;
        if ({MA, MD} !== {addr, emd}) begin
            errors++;
            $display("FAIL end_hold: got MA=%h MD=%h expected %h %h", MA, MD, addr, emd);
        end
        last_ma = addr;
        last_md = emd;
        if (tail) begin
            ACK = 1'($urandom_range(0, 1));
            @(posedge CLK); #1;
            ACK = 1'b0;
            checks++;
            if ({MWE, BUSY, DONE, ODDERR, NXM} !== 5'b00000) begin
                errors++;
                $display("FAIL tail_idle: got %b expected 00000",
                         {MWE, BUSY, DONE, ODDERR, NXM});
            end
            checks++;
            if ({MA, MD} !== {last_ma, last_md}) begin
                errors++;
                $display("FAIL tail_hold: got MA=%h MD=%h expected %h %h",
                         MA, MD, last_ma, last_md);
            end
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({MA, MD, MBE, MWE, BUSY, DONE, ODDERR, NXM} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs: got MA=%h MD=%h MBE=%b flags=%b expected all 0",
                     MA, MD, MBE, {MWE, BUSY, DONE, ODDERR, NXM});
        end
        repeat (2) @(posedge CLK);
        #1;
        RSTN = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if ({MA, MD, MBE, MWE, BUSY, DONE, ODDERR, NXM} !== 38'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got MA=%h MD=%h flags=%b expected all 0",
                     MA, MD, {MBE, MWE, BUSY, DONE, ODDERR, NXM});
        end
    endtask

    task automatic test_odd_word(input logic [15:0] addr, input logic [15:0] b);
        START = 1'b1; WORD = 1'b1; ADDR = addr | 16'h0001; B = b;
        @(posedge CLK); #1;
        START = 1'b0;
        checks++;
        if ({ODDERR, MWE, BUSY, DONE, NXM} !== 5'b10000) begin
            errors++;
            $display("FAIL odd_pulse: got ODDERR/MWE/BUSY/DONE/NXM=%b expected 10000",
                     {ODDERR, MWE, BUSY, DONE, NXM});
        end
        checks++;
        if ({MA, MD, MBE} !== {last_ma, last_md, 2'b00}) begin
            errors++;
            $display("FAIL odd_hold: got MA=%h MD=%h MBE=%b expected %h %h 00",
                     MA, MD, MBE, last_ma, last_md);
        end
        @(posedge CLK); #1;
        checks++;
        if ({ODDERR, MWE, BUSY} !== 3'b000) begin
            errors++;
            $display("FAIL odd_one_cycle: got ODDERR/MWE/BUSY=%b expected 000",
                     {ODDERR, MWE, BUSY});
        end
    endtask

    task automatic test_byte_odd;
        do_write(1'b0, 16'h1235, 16'hA7C3, 2, 1'b0, 1'b1);
    endtask

    task automatic test_word_even;
        do_write(1'b1, 16'h0400, 16'hBEEF, 3, 1'b0, 1'b1);
    endtask

    task automatic test_timeout;
        do_write(1'b1, 16'h0810, 16'($urandom), 0, 1'b0, 1'b1);
        do_write(1'b0, 16'h0811, 16'($urandom), TMO, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        // First write sees START during WRITE; the second START coincides with its DONE.
        do_write(1'b0, 16'h2000, 16'h1234, 3, 1'b1, 1'b0);
        do_write(1'b1, 16'h3002, 16'hCAFE, 1, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_write;
        START = 1'b1; WORD = 1'b1; ADDR = 16'h5552; B = 16'($urandom);
        @(posedge CLK); #1;
        START = 1'b0;
        @(posedge CLK); #3;
        RSTN = 1'b0;
        #1;
        checks++;
        if ({MA, MD, MBE, MWE, BUSY, DONE, ODDERR, NXM} !== 38'd0) begin
            errors++;
            $display("FAIL async_reset: got MA=%h MD=%h flags=%b expected all 0",
                     MA, MD, {MBE, MWE, BUSY, DONE, ODDERR, NXM});
        end
        ACK = 1'b1;
        @(posedge CLK); #1;
        ACK = 1'b0;
        #2;
        RSTN = 1'b1;
        repeat (TMO + 2) begin
            @(posedge CLK); #1;
            checks++;
            if ({MWE, BUSY, DONE, ODDERR, NXM} !== 5'b00000) begin
                errors++;
                $display("FAIL after_reset: got %b expected 00000",
                         {MWE, BUSY, DONE, ODDERR, NXM});
            end
        end
        last_ma = '0;
        last_md = '0;
        checks++;
        if ({MA, MD} !== 32'd0) begin
            errors++;
            $display("FAIL after_reset_bus: got MA=%h MD=%h expected 0 0", MA, MD);
        end
        do_write(1'b0, 16'h0042, 16'h00A5, 1, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
        repeat (30) begin
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom);
            d = 16'($urandom);
            if (w && a[0]) begin
                test_odd_word(a, d);
            end else begin
                do_write(w, a, d, int'($urandom_range(0, TMO + 1)),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_byte_odd();
        test_word_even();
        test_odd_word(16'h0401, 16'h5A5A);
        test_timeout();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/memwr_seq.md
Name: memwr_seq

Overview:
- Write-side counterpart of the memory read path: takes a store request from the datapath (address, BBUS data, byte/word) and runs one memory write cycle.
- Steers byte data onto the correct lane and generates byte enables.
- Runs the write strobe / acknowledge handshake with memory.
- Flags an odd-address word write, or a missing acknowledge (nonexistent memory), as a one-cycle error pulse for the trap logic.

Parameters:
- TMO_CYCLES, 15, number of WRITE-state cycles without ACK before NXM is raised (legal range 1..255).
- TMO_W, 8, width of the timeout counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- START  input  1  request strobe; sampled only in IDLE.
- WORD  input  1  1 = word write; 0 = byte write.
- ADDR  input  16  byte address of the write.
- B  input  16  write data from BBUS; byte data is in B[07:00].
- ACK  input  1  memory write acknowledge; sampled on CLK.
- MA  output  16  memory address.
- MD  output  16  memory write data.
- MBE  output  2  byte enables: [1] = high byte, [0] = low byte.
- MWE  output  1  write strobe.
- BUSY  output  1  1 while a write cycle is in progress.
- DONE  output  1  one-cycle pulse: write completed.
- ODDERR  output  1  one-cycle pulse: word write to an odd address was rejected.
- NXM  output  1  one-cycle pulse: timeout, memory did not acknowledge.

Behaviour:

Reset:
- RSTN low forces all of the following immediately, regardless of CLK: MA=0, MD=0, MBE=0, MWE=0, BUSY=0, DONE=0, ODDERR=0, NXM=0, timeout counter=0, state=IDLE.
- Reset mid-write abandons the cycle. No DONE or NXM is produced.

States:
- IDLE
- WRITE

IDLE:
- Outputs: MWE=0, BUSY=0, MBE=0.
- START=1 with WORD=1 and ADDR[0]=1:
  - No memory cycle; MA, MD, MBE unchanged.
  - ODDERR=1 for the following cycle.
  - Stay in IDLE.
- START=1 otherwise, latch at the edge and enter WRITE:
  - MA = ADDR (full address, bit 0 included).
  - Word: MD = B, MBE = 2'b11.
  - Byte: MD = {B[07:00], B[07:00]} (replicated on both lanes); MBE = 2'b10 if ADDR[0]=1, else 2'b01.
  - Timeout counter = 0.
- Latency: MWE and BUSY rise in the cycle directly after the START edge.

WRITE:
- Outputs: MWE=1, BUSY=1. MA, MD, MBE held stable for the whole state.
- ACK=1 at an edge:
  - Next cycle: IDLE, MWE=0, BUSY=0, MBE=0, DONE=1 for exactly one cycle.
- ACK=0 at an edge:
  - Counter increments.
  - If this edge ends the TMO_CYCLES-th WRITE cycle: go to IDLE, MWE=0, BUSY=0, MBE=0, NXM=1 for one cycle.
- ACK and the timeout landing on the same edge: ACK wins; DONE is raised, NXM is not.
- Minimum write: MWE high for 1 cycle (ACK in the first WRITE cycle); DONE appears 2 cycles after the START edge.

Other rules:
- START while in WRITE is ignored. No queuing; the caller retries after DONE, NXM or ODDERR.
- START in the same cycle as a DONE or NXM pulse (FSM already back in IDLE) is accepted normally.
- MA and MD hold their last values in IDLE until the next accepted START. MBE returns to 0 in IDLE.
- DONE, ODDERR and NXM are mutually exclusive; at most one is high in any cycle.
- ACK while in IDLE is ignored.

Test Plan:
1. Byte write, odd address: START, WORD=0, ADDR=16'h1235, B=16'hA7C3, ACK on 2nd WRITE cycle -> MA=16'h1235, MD=16'hC3C3, MBE=2'b10, MWE high 2 cycles, one DONE pulse, BUSY back to 0.
2. Word write, even address: WORD=1, ADDR=16'h0400, B=16'hBEEF, ACK on 3rd WRITE cycle -> MD=16'hBEEF, MBE=2'b11, MWE high 3 cycles, DONE 4 cycles after START edge.
3. Odd word write: WORD=1, ADDR=16'h0401 -> MWE never asserts, BUSY stays 0, ODDERR=1 for exactly one cycle, MA/MD unchanged from the previous test.
4. Timeout with TMO_CYCLES=4: ACK held 0 -> MWE high 4 cycles, then NXM one-cycle pulse, no DONE. Repeat with ACK rising in the 4th WRITE cycle -> DONE, no NXM.
5. START during WRITE with a different ADDR -> ignored; MA stays at the first address, exactly one DONE. START coincident with that DONE -> accepted, new write begins.
6. RSTN pulsed low mid-WRITE, between clock edges -> all outputs 0 immediately, no DONE or NXM afterwards, next START behaves as from a clean reset.
